// File: rtl/irq_ctrl.sv
// Interrupt request controller: edge-detects button/switch sources, latches them
// into a masked pending register and presents one at a time to the core with an ack/holdoff handshake.
module irq_ctrl #(
    parameter int NUM_BTN        = 4,
    parameter int NUM_SW         = 3,
    parameter int HOLDOFF_CYCLES = 16,
    parameter int ARM_CYCLES     = 3
) (
    input  logic                      CLK,
    input  logic                      nrst,
    input  logic [NUM_BTN-1:0]        btn_in,
    input  logic [NUM_SW-1:0]         switch_in,
    input  logic [NUM_BTN+NUM_SW-1:0] int_en,
    input  logic                      int_ack,
    output logic                      int_sig,
    output logic [2:0]                int_id,
    output logic [NUM_BTN+NUM_SW-1:0] int_pending
);

    localparam int NUM_SRC = NUM_BTN + NUM_SW;
    localparam int ARM_W   = (ARM_CYCLES < 1) ? 1 : $clog2(ARM_CYCLES + 1);
    localparam int HOLD_W  = (HOLDOFF_CYCLES < 2) ? 1 : $clog2(HOLDOFF_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ASSERT  = 2'b01,
        ST_HOLDOFF = 2'b10
    } state_t;

    // Fixed priority: lowest set index wins.
    function automatic logic [2:0] first_set(input logic [NUM_SRC-1:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            idx = vec[i] ? 3'(i) : idx;
        end
        return idx;
    endfunction

    logic [NUM_SW-1:0]  sw_s1_r;
    logic [NUM_SW-1:0]  sw_s2_r;
    logic [NUM_SW-1:0]  sw_q_r;
    logic [NUM_BTN-1:0] btn_q_r;
    logic [ARM_W-1:0]   arm_cnt_r;
    logic [HOLD_W-1:0]  hold_cnt_r;
    logic [NUM_SRC-1:0] pending_r;
    logic [2:0]         int_id_r;
    logic               int_sig_r;
    logic               ack_q_r;
    state_t             state_r;

    logic               armed_s;
    logic               ack_take_s;
    logic [NUM_SRC-1:0] evt_s;
    logic [NUM_SRC-1:0] set_s;
    logic [NUM_SRC-1:0] clr_s;
    logic [NUM_SRC-1:0] pending_nx_s;
    state_t             state_nx_s;
    logic [2:0]         id_nx_s;
    logic [HOLD_W-1:0]  hold_nx_s;
    logic               sig_nx_s;

    // Switch synchronizer and edge history registers; these run even while unarmed.
    always_ff @(posedge CLK) begin
        if (!nrst) begin
            sw_s1_r <= {NUM_SW{1'b0}};
            sw_s2_r <= {NUM_SW{1'b0}};
            sw_q_r  <= {NUM_SW{1'b0}};
            btn_q_r <= {NUM_BTN{1'b0}};
        end else begin
            sw_s1_r <= switch_in;
            sw_s2_r <= sw_s1_r;
            sw_q_r  <= sw_s2_r;
            btn_q_r <= btn_in;
        end
    end

    // Arm counter masks the synchronizer settling edge seen right after reset.
    always_ff @(posedge CLK) begin
        if (!nrst) begin
            arm_cnt_r <= ARM_W'(ARM_CYCLES);
        end else if (arm_cnt_r != {ARM_W{1'b0}}) begin
            arm_cnt_r <= arm_cnt_r - ARM_W'(1);
        end else begin
            arm_cnt_r <= arm_cnt_r;
        end
    end

    // Event detection and pending set/clear; a new event beats a same-cycle clear.
    always_comb begin
        armed_s    = (arm_cnt_r == {ARM_W{1'b0}});
        evt_s      = {sw_s2_r ^ sw_q_r, btn_in & ~btn_q_r};
        ack_take_s = (state_r == ST_ASSERT) && int_ack && !ack_q_r;
        if (armed_s) begin
            set_s = evt_s & int_en;
        end else begin
            set_s = {NUM_SRC{1'b0}};
        end
        if (ack_take_s) begin
            clr_s = {{(NUM_SRC-1){1'b0}}, 1'b1} << int_id_r;
        end else begin
            clr_s = {NUM_SRC{1'b0}};
        end
        pending_nx_s = (pending_r & ~clr_s) | set_s;
    end

    // Next-state logic for the request handshake.
    always_comb begin
        state_nx_s = state_r;
        id_nx_s    = int_id_r;
        hold_nx_s  = hold_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (pending_r != {NUM_SRC{1'b0}}) begin
                    state_nx_s = ST_ASSERT;
                    id_nx_s    = first_set(pending_r);
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ASSERT: begin
                if (ack_take_s) begin
                    state_nx_s = ST_HOLDOFF;
                    hold_nx_s  = HOLD_W'(HOLDOFF_CYCLES - 1);
                end else begin
                    state_nx_s = ST_ASSERT;
                end
            end
            ST_HOLDOFF: begin
                if (hold_cnt_r == {HOLD_W{1'b0}}) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    hold_nx_s = hold_cnt_r - HOLD_W'(1);
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                hold_nx_s  = {HOLD_W{1'b0}};
            end
        endcase
    end

    // Output decode from the next state so int_sig comes straight from a flop.
    always_comb begin
        if (state_nx_s == ST_ASSERT) begin
            sig_nx_s = 1'b1;
        end else begin
            sig_nx_s = 1'b0;
        end
    end

    // State, pending and output registers.
    always_ff @(posedge CLK) begin
        if (!nrst) begin
            state_r    <= ST_IDLE;
            int_id_r   <= 3'd0;
            hold_cnt_r <= {HOLD_W{1'b0}};
            int_sig_r  <= 1'b0;
            pending_r  <= {NUM_SRC{1'b0}};
            ack_q_r    <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            int_id_r   <= id_nx_s;
            hold_cnt_r <= hold_nx_s;
            int_sig_r  <= sig_nx_s;
            pending_r  <= pending_nx_s;
            ack_q_r    <= int_ack;
        end
    end

    assign int_sig     = int_sig_r;
    assign int_id      = int_id_r;
    assign int_pending = pending_r;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: reset/arm window, latency, masking, priority, holdoff and reset abort.
module tb_irq_ctrl;

    logic       CLK = 1'b0;
    logic       nrst;
    logic [3:0] btn_in;
    logic [2:0] switch_in;
    logic [6:0] int_en;
    logic       int_ack;
    logic       int_sig;
    logic [2:0] int_id;
    logic [6:0] int_pending;

    int checks   = 0;
    int failures = 0;

    irq_ctrl #(.NUM_BTN(4), .NUM_SW(3), .HOLDOFF_CYCLES(16), .ARM_CYCLES(3)) dut (
        .CLK(CLK), .nrst(nrst), .btn_in(btn_in), .switch_in(switch_in), .int_en(int_en),
        .int_ack(int_ack), .int_sig(int_sig), .int_id(int_id), .int_pending(int_pending)
    );

    always #5 CLK = ~CLK;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic ack_once();
        int_ack = 1'b1;
        step(1);
        int_ack = 1'b0;
    endtask

    task automatic test_reset();
        nrst = 1'b0; btn_in = 4'h0; switch_in = 3'b101; int_en = 7'h7F; int_ack = 1'b0;
        step(2);
        checks++;
        if ({int_sig, int_id, int_pending} !== {1'b0, 3'd0, 7'h00}) begin
            failures++; $display("FAIL reset_state: got sig/id/pend %b/%0d/%h want 0/0/00", int_sig, int_id, int_pending);
        end
        nrst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            checks++;
            if ({int_sig, int_pending} !== {1'b0, 7'h00}) begin
                failures++; $display("FAIL arm_window cyc%0d: got sig/pend %b/%h want 0/00", i, int_sig, int_pending);
            end
        end
    endtask

    task automatic test_button();
        btn_in[2] = 1'b1;
        step(1);
        checks++;
        if ({int_sig, int_pending} !== {1'b0, 7'h04}) begin
            failures++; $display("FAIL btn_pend_set: got sig/pend %b/%h want 0/04", int_sig, int_pending);
        end
        step(1);
        checks++;
        if ({int_sig, int_id, int_pending} !== {1'b1, 3'd2, 7'h04}) begin
            failures++; $display("FAIL btn_assert: got sig/id/pend %b/%0d/%h want 1/2/04", int_sig, int_id, int_pending);
        end
        ack_once();
        btn_in[2] = 1'b0;
        checks++;
        if ({int_sig, int_pending} !== {1'b0, 7'h00}) begin
            failures++; $display("FAIL btn_ack_clear: got sig/pend %b/%h want 0/00", int_sig, int_pending);
        end
        step(1);
        btn_in[2] = 1'b1;
        step(1);
        btn_in[2] = 1'b0;
        checks++;
        if ({int_sig, int_pending} !== {1'b0, 7'h04}) begin
            failures++; $display("FAIL holdoff_latch: got sig/pend %b/%h want 0/04", int_sig, int_pending);
        end
        ack_once();
        checks++;
        if ({int_sig, int_pending} !== {1'b0, 7'h04}) begin
            failures++; $display("FAIL holdoff_ack_ignored: got sig/pend %b/%h want 0/04", int_sig, int_pending);
        end
        for (int i = 0; i < 13; i++) begin
            step(1);
            checks++;
            if (int_sig !== 1'b0) begin
                failures++; $display("FAIL holdoff_quiet cyc%0d: got sig %b want 0", i, int_sig);
            end
        end
        step(1);
        checks++;
        if ({int_sig, int_id} !== {1'b1, 3'd2}) begin
            failures++; $display("FAIL holdoff_reassert: got sig/id %b/%0d want 1/2", int_sig, int_id);
        end
        ack_once();
        step(16);
    endtask

    task automatic test_simultaneous();
        btn_in[3] = 1'b1; switch_in = 3'b100;
        step(1);
        checks++;
        if (int_pending !== 7'h08) begin
            failures++; $display("FAIL simul_btn_first: got pend %h want 08", int_pending);
        end
        step(1);
        checks++;
        if ({int_sig, int_id} !== {1'b1, 3'd3}) begin
            failures++; $display("FAIL simul_id3: got sig/id %b/%0d want 1/3", int_sig, int_id);
        end
        step(1);
        checks++;
        if ({int_sig, int_id, int_pending} !== {1'b1, 3'd3, 7'h18}) begin
            failures++; $display("FAIL simul_sw_latency: got sig/id/pend %b/%0d/%h want 1/3/18", int_sig, int_id, int_pending);
        end
        btn_in[3] = 1'b0;
        ack_once();
        checks++;
        if ({int_sig, int_pending} !== {1'b0, 7'h10}) begin
            failures++; $display("FAIL simul_ack3: got sig/pend %b/%h want 0/10", int_sig, int_pending);
        end
        step(16);
        checks++;
        if (int_sig !== 1'b0) begin
            failures++; $display("FAIL simul_holdoff_end: got sig %b want 0", int_sig);
        end
        step(1);
        checks++;
        if ({int_sig, int_id} !== {1'b1, 3'd4}) begin
            failures++; $display("FAIL simul_id4: got sig/id %b/%0d want 1/4", int_sig, int_id);
        end
        ack_once();
        step(16);
    endtask

    task automatic test_mask();
        int_en = 7'h7E; btn_in[0] = 1'b1;
        step(3);
        checks++;
        if ({int_sig, int_pending} !== {1'b0, 7'h00}) begin
            failures++; $display("FAIL mask_drop: got sig/pend %b/%h want 0/00", int_sig, int_pending);
        end
        int_en = 7'h7F;
        step(3);
        checks++;
        if ({int_sig, int_pending} !== {1'b0, 7'h00}) begin
            failures++; $display("FAIL mask_no_defer: got sig/pend %b/%h want 0/00", int_sig, int_pending);
        end
        btn_in[0] = 1'b0;
        step(1);
    endtask

    task automatic test_no_preempt();
        switch_in = 3'b110;
        step(3);
        checks++;
        if ({int_sig, int_pending} !== {1'b0, 7'h20}) begin
            failures++; $display("FAIL sw5_pend: got sig/pend %b/%h want 0/20", int_sig, int_pending);
        end
        step(1);
        checks++;
        if ({int_sig, int_id} !== {1'b1, 3'd5}) begin
            failures++; $display("FAIL sw5_assert: got sig/id %b/%0d want 1/5", int_sig, int_id);
        end
        btn_in[1] = 1'b1;
        step(1);
        btn_in[1] = 1'b0;
        step(1);
        checks++;
        if ({int_sig, int_id, int_pending} !== {1'b1, 3'd5, 7'h22}) begin
            failures++; $display("FAIL no_preempt: got sig/id/pend %b/%0d/%h want 1/5/22", int_sig, int_id, int_pending);
        end
        switch_in = 3'b100;
        step(2);
        ack_once();
        checks++;
        if ({int_sig, int_pending} !== {1'b0, 7'h22}) begin
            failures++; $display("FAIL set_beats_clear: got sig/pend %b/%h want 0/22", int_sig, int_pending);
        end
        step(17);
        checks++;
        if ({int_sig, int_id} !== {1'b1, 3'd1}) begin
            failures++; $display("FAIL serve_id1: got sig/id %b/%0d want 1/1", int_sig, int_id);
        end
        ack_once();
        step(17);
        checks++;
        if ({int_sig, int_id, int_pending} !== {1'b1, 3'd5, 7'h20}) begin
            failures++; $display("FAIL serve_id5_again: got sig/id/pend %b/%0d/%h want 1/5/20", int_sig, int_id, int_pending);
        end
        ack_once();
        step(16);
    endtask

    task automatic test_reset_abort();
        btn_in[0] = 1'b1; switch_in = 3'b000;
        step(3);
        checks++;
        if ({int_sig, int_id, int_pending} !== {1'b1, 3'd0, 7'h41}) begin
            failures++; $display("FAIL abort_setup: got sig/id/pend %b/%0d/%h want 1/0/41", int_sig, int_id, int_pending);
        end
        nrst = 1'b0;
        step(1);
        nrst = 1'b1;
        checks++;
        if ({int_sig, int_id, int_pending} !== {1'b0, 3'd0, 7'h00}) begin
            failures++; $display("FAIL abort_cleared: got sig/id/pend %b/%0d/%h want 0/0/00", int_sig, int_id, int_pending);
        end
        step(4);
        checks++;
        if ({int_sig, int_pending} !== {1'b0, 7'h00}) begin
            failures++; $display("FAIL abort_rearm_quiet: got sig/pend %b/%h want 0/00", int_sig, int_pending);
        end
        btn_in = 4'b1000;
        step(1);
        checks++;
        if ({int_sig, int_pending} !== {1'b0, 7'h08}) begin
            failures++; $display("FAIL abort_idle_pend: got sig/pend %b/%h want 0/08", int_sig, int_pending);
        end
        step(1);
        checks++;
        if ({int_sig, int_id} !== {1'b1, 3'd3}) begin
            failures++; $display("FAIL abort_idle_serve: got sig/id %b/%0d want 1/3", int_sig, int_id);
        end
    endtask

    initial begin
        test_reset();
        test_button();
        test_simultaneous();
        test_mask();
        test_no_preempt();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt request controller between the debounced button outputs / raw switch inputs and the RISC-V core's int_sig input.
- Replaces the plain OR of the inputs with edge detection, a per-source pending latch and enable mask, fixed priority, and an ack handshake with the core.
- A post-ack holdoff period keeps a bouncing source from re-interrupting the core back-to-back.

Parameters:
- NUM_BTN, 4: number of debounced button sources; source indices 0..NUM_BTN-1.
- NUM_SW, 3: number of switch sources; source indices NUM_BTN..NUM_BTN+NUM_SW-1.
- HOLDOFF_CYCLES, 16: idle cycles forced after each ack. Must be ≥1.
- ARM_CYCLES, 3: cycles after reset during which edges are ignored.

Ports:
- CLK  input  1  system clock (clocking-wizard output).
- nrst  input  1  synchronous active-low reset.
- btn_in  input  NUM_BTN  debounced buttons, already synchronous to CLK.
- switch_in  input  NUM_SW  raw asynchronous switches.
- int_en  input  NUM_BTN+NUM_SW  per-source enable mask.
- int_ack  input  1  one-cycle ack from the core for the currently presented source.
- int_sig  output  1  interrupt request to the core.
- int_id  output  3  index of the source being presented; valid while int_sig=1.
- int_pending  output  NUM_BTN+NUM_SW  pending register, exposed for status reads.

Behaviour:
- Reset: CLK is the only clock; reset is synchronous, active-low, sampled on the CLK rising edge while nrst=0. All registers are cleared to 0: int_sig=0, int_id=0, int_pending=0, sync/edge flops=0, arm counter=ARM_CYCLES, FSM=IDLE. Reset mid-operation aborts any request immediately and loses all pending bits.
- Input conditioning:
  - switch_in passes through a 2-flop synchronizer (sw_s1, sw_s2), then an edge register sw_q.
  - btn_in goes straight to an edge register btn_q.
- Events:
  - Button event = btn_in & ~btn_q (rising edge only).
  - Switch event = sw_s2 ^ sw_q (either edge).
  - Edge registers keep updating while unarmed, but all events are suppressed until the arm counter reaches 0. The counter decrements once per cycle after reset.
- Pending register:
  - Set: int_pending[i] is set at the same edge its event is detected, but only if int_en[i]=1. Events on masked sources are dropped, not deferred.
  - Clear: int_pending[int_id] clears on an accepted ack.
  - Simultaneous set and clear of the same bit: set wins, so the new event is kept.
  - Deasserting int_en[i] does not clear an already-pending bit; that bit remains eligible for selection.
- Latency:
  - Button high before edge k → pending set at edge k → int_sig=1 after edge k+1.
  - Switch change before edge k → pending set at edge k+2 → int_sig=1 after edge k+3.
- FSM states and transitions:
  - IDLE: int_sig=0. If int_pending≠0, latch int_id = lowest set index (fixed priority, index 0 highest) and go to ASSERT.
  - ASSERT: int_sig=1 and int_id is held stable. Newly pending higher-priority sources do not preempt the current one. On int_ack=1: clear int_pending[int_id], load holdoff counter with HOLDOFF_CYCLES-1, go to HOLDOFF.
  - HOLDOFF: int_sig=0. Events are still latched into int_pending. The counter decrements each cycle; when it reaches 0, go to IDLE.
- int_ack handling: only honoured in ASSERT; ignored in IDLE and HOLDOFF. An ack that stays high for multiple cycles counts as one ack.
- No timeout: ASSERT holds indefinitely until acked.
- int_id width: fixed at 3 bits, so NUM_BTN+NUM_SW ≤ 8.

Test Plan:
1. Reset release with switch_in=3'b101 and int_en=7'h7F, no further toggles → int_pending stays 0 and int_sig stays 0 for 20 cycles (arm window suppresses the synchronizer settling edge).
2. btn_in[2] rises at edge k, int_en=7'h7F → int_pending=7'h04 after edge k, int_sig=1 and int_id=2 after edge k+1. One-cycle int_ack → int_pending=0 and int_sig=0 next cycle. int_sig stays 0 for 16 cycles even if btn_in[2] pulses again; that pulse sets int_pending=7'h04 and int_sig reasserts right after holdoff ends.
3. btn_in[3] and switch_in[0] change in the same cycle → int_pending reaches 7'h18. int_id=3 first; after ack and holdoff, int_id=4.
4. int_en=7'h7E, btn_in[0] rises → int_pending stays 0 and int_sig stays 0. Then set int_en=7'h7F without a new edge → still no request.
5. In ASSERT serving id 5, btn_in[1] rises → int_id stays 5 until acked, then 1 is served. A new switch 5 edge arriving in the same cycle as its ack → int_pending[5] remains 1.
6. nrst=0 for one cycle while int_sig=1 and int_pending=7'h41 → on the next cycle all outputs are 0 and the FSM is in IDLE.
